// File: rtl/uart_pkg_types.sv
// Shared types and constants for the UART receive path.
// Optional even-parity support is selected with UART_RX_PARITY_EN.
package uart_pkg_types;

    localparam int unsigned UART_WORD_W          = 16;
    localparam int unsigned UART_BYTE_W          = 8;
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 10416;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    typedef enum logic {
        PH_HIGH,
        PH_LOW
    } phase_t;

endpackage

// File: rtl/uart_rx_byte.sv
// Byte-level 8N1 receiver: synchronizer, bit FSM and baud counter.
// Define UART_RX_PARITY_EN to expect an even-parity bit after bit 7.
module uart_rx_byte
    import uart_pkg_types::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   uart_rx,
    output logic [UART_BYTE_W-1:0] byte_data,
    output logic                   byte_valid,
    output logic                   byte_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(UART_BYTE_W);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_BYTE_W - 1);

    logic                   rx_m;
    logic                   rx_s;
    rx_state_t              state;
    rx_state_t              state_n;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_n;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       idx_n;
    logic [UART_BYTE_W-1:0] shreg;
    logic [UART_BYTE_W-1:0] shreg_n;
    logic                   byte_valid_n;
    logic                   byte_err_n;
    logic                   bit_end_c;
    logic                   par_ok_c;

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    logic par_bad_n;
    assign par_ok_c = !par_bad;
`else
    assign par_ok_c = 1'b1;
`endif

    assign bit_end_c = (cnt == BIT_END);
    assign byte_data = shreg;

    // State and datapath registers; the synchronizer idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
`endif
        end else begin
            rx_m       <= uart_rx;
            rx_s       <= rx_m;
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            shreg      <= shreg_n;
            byte_valid <= byte_valid_n;
            byte_err   <= byte_err_n;
`ifdef UART_RX_PARITY_EN
            par_bad    <= par_bad_n;
`endif
        end
    end

    // Next-state logic: every bit is sampled at its centre count.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt + CNT_W'(1);
        idx_n        = idx;
        shreg_n      = shreg;
        byte_valid_n = 1'b0;
        byte_err_n   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n    = par_bad;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) begin
                    state_n = START;
                end
            end
            START: begin
                if (cnt == HALF_END) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
                    par_bad_n = 1'b0;
`endif
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[UART_BYTE_W-1:1]};
                    if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_end_c) begin
                    cnt_n   = '0;
                    state_n = STOP;
                    if ((^shreg) != rx_s) begin
                        par_bad_n  = 1'b1;
                        byte_err_n = 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                // A parity error has already been reported, so only one pulse per frame.
                if (bit_end_c) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        state_n      = IDLE;
                        byte_valid_n = par_ok_c;
                    end else begin
                        state_n    = WAIT_HIGH;
                        byte_err_n = par_ok_c;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_n = '0;
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/uart_rx_word.sv
// Pairs received UART bytes into 16-bit words on a valid/ready output.
// Define UART_RX_PARITY_EN to enable even parity in the byte receiver.
module uart_rx_word
    import uart_pkg_types::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   uart_rx,
    output logic [UART_WORD_W-1:0] data,
    output logic                   valid,
    input  logic                   ready,
    output logic                   frame_err,
    output logic                   overrun
);

    logic [UART_BYTE_W-1:0] byte_data;
    logic                   byte_valid;
    logic                   byte_err;
    phase_t                 phase;
    logic [UART_BYTE_W-1:0] hi;
    logic                   word_done_c;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .byte_err  (byte_err)
    );

    assign word_done_c = byte_valid && (phase == PH_LOW);
    assign frame_err   = byte_err;

    // Word assembler and output register; a full output drops the new word.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase   <= PH_HIGH;
            hi      <= '0;
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (byte_err) begin
                phase <= PH_HIGH;
            end else if (byte_valid) begin
                if (phase == PH_HIGH) begin
                    hi    <= byte_data;
                    phase <= PH_LOW;
                end else begin
                    phase <= PH_HIGH;
                end
            end
            if (word_done_c) begin
                if (!valid || ready) begin
                    data  <= {hi, byte_data};
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed self-checking bench for uart_rx_word at 16 clocks per bit.
// Compile with UART_RX_PARITY_EN defined to add the parity scenario.
module tb_uart_rx_word;

    localparam int unsigned CPB = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_rx;
    logic [15:0] data;
    logic        valid;
    logic        ready;
    logic        frame_err;
    logic        overrun;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_ferr = 0;
    int n_ovr  = 0;
    int n_acc  = 0;
    logic [15:0] last_acc = 16'h0;

    uart_rx_word #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Observe pulses and accepted words at each rising edge.
    always @(posedge clk) begin
        if (frame_err) n_ferr++;
        if (overrun) n_ovr++;
        if (valid && ready) begin
            n_acc++;
            last_acc = data;
        end
    end

    task automatic drive_bits(input logic v, input int nbits);
        @(negedge clk) uart_rx = v;
        repeat (nbits * CPB - 1) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int stop_low, input logic par_flip);
        drive_bits(1'b0, 1);
        for (int i = 0; i < 8; i++) drive_bits(b[i], 1);
`ifdef UART_RX_PARITY_EN
        drive_bits((^b) ^ par_flip, 1);
`else
        if (par_flip) drive_bits(1'b1, 0);
`endif
        if (stop_low > 0) begin
            drive_bits(1'b0, stop_low);
            drive_bits(1'b1, 2);
        end else begin
            drive_bits(1'b1, 1);
        end
    endtask

    task automatic idle_bits(input int n);
        drive_bits(1'b1, n);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++; if (data !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0000", data); end
        n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        rst = 1'b0;
        idle_bits(2);
    endtask

    task automatic test_basic;
        int a0, f0, o0;
        a0 = n_acc; f0 = n_ferr; o0 = n_ovr;
        ready = 1'b1;
        send_byte(8'h4f, 0, 1'b0);
        send_byte(8'h3e, 0, 1'b0);
        idle_bits(1);
        n_cmp++; if (n_acc - a0 !== 1) begin n_fail++; $display("FAIL basic_count: got %0d words want 1", n_acc - a0); end
        n_cmp++; if (last_acc !== 16'h4f3e) begin n_fail++; $display("FAIL basic_data: got %h want 4f3e", last_acc); end
        n_cmp++; if (n_ferr - f0 !== 0) begin n_fail++; $display("FAIL basic_frame_err: got %0d want 0", n_ferr - f0); end
        n_cmp++; if (n_ovr - o0 !== 0) begin n_fail++; $display("FAIL basic_overrun: got %0d want 0", n_ovr - o0); end
        n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %b want 0", valid); end
    endtask

    task automatic test_overrun;
        int a0, o0;
        a0 = n_acc; o0 = n_ovr;
        ready = 1'b0;
        send_byte(8'h12, 0, 1'b0);
        send_byte(8'h34, 0, 1'b0);
        idle_bits(1);
        n_cmp++; if (valid !== 1'b1) begin n_fail++; $display("FAIL ovr_first_valid: got %b want 1", valid); end
        n_cmp++; if (data !== 16'h1234) begin n_fail++; $display("FAIL ovr_first_data: got %h want 1234", data); end
        send_byte(8'hab, 0, 1'b0);
        send_byte(8'hcd, 0, 1'b0);
        idle_bits(1);
        n_cmp++; if (data !== 16'h1234) begin n_fail++; $display("FAIL ovr_data_held: got %h want 1234", data); end
        n_cmp++; if (valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_held: got %b want 1", valid); end
        n_cmp++; if (n_ovr - o0 !== 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d want 1", n_ovr - o0); end
        @(negedge clk) ready = 1'b1;
        @(negedge clk) ready = 1'b0;
        n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ovr_valid_drop: got %b want 0", valid); end
        n_cmp++; if (n_acc - a0 !== 1) begin n_fail++; $display("FAIL ovr_accepts: got %0d want 1", n_acc - a0); end
    endtask

    task automatic test_frame_err;
        int a0, f0;
        a0 = n_acc; f0 = n_ferr;
        ready = 1'b1;
        send_byte(8'h55, 2, 1'b0);
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        idle_bits(1);
        n_cmp++; if (n_ferr - f0 !== 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d want 1", n_ferr - f0); end
        n_cmp++; if (n_acc - a0 !== 1) begin n_fail++; $display("FAIL ferr_words: got %0d want 1", n_acc - a0); end
        n_cmp++; if (last_acc !== 16'h0102) begin n_fail++; $display("FAIL ferr_data: got %h want 0102", last_acc); end
    endtask

    task automatic test_glitch;
        int a0, f0;
        a0 = n_acc; f0 = n_ferr;
        ready = 1'b1;
        @(negedge clk) uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        idle_bits(2);
        send_byte(8'ha5, 0, 1'b0);
        send_byte(8'h5a, 0, 1'b0);
        idle_bits(1);
        n_cmp++; if (n_ferr - f0 !== 0) begin n_fail++; $display("FAIL glitch_frame_err: got %0d want 0", n_ferr - f0); end
        n_cmp++; if (n_acc - a0 !== 1) begin n_fail++; $display("FAIL glitch_words: got %0d want 1", n_acc - a0); end
        n_cmp++; if (last_acc !== 16'ha55a) begin n_fail++; $display("FAIL glitch_data: got %h want a55a", last_acc); end
    endtask

    task automatic test_reset_mid;
        int a0;
        logic [7:0] b;
        ready = 1'b1;
        // A lone byte leaves the assembler holding a high byte that reset must discard.
        send_byte(8'h99, 0, 1'b0);
        idle_bits(1);
        b = 8'hde;
        drive_bits(1'b0, 1);
        for (int i = 0; i < 4; i++) drive_bits(b[i], 1);
        @(negedge clk) begin rst = 1'b1; uart_rx = 1'b1; end
        repeat (3) @(negedge clk);
        n_cmp++; if (data !== 16'h0) begin n_fail++; $display("FAIL rstmid_data: got %h want 0000", data); end
        n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", valid); end
        n_cmp++; if ({frame_err, overrun} !== 2'b00) begin n_fail++; $display("FAIL rstmid_pulses: got %b want 00", {frame_err, overrun}); end
        rst = 1'b0;
        idle_bits(2);
        a0 = n_acc;
        send_byte(8'hde, 0, 1'b0);
        send_byte(8'had, 0, 1'b0);
        idle_bits(1);
        n_cmp++; if (n_acc - a0 !== 1) begin n_fail++; $display("FAIL rstmid_words: got %0d want 1", n_acc - a0); end
        n_cmp++; if (last_acc !== 16'hdead) begin n_fail++; $display("FAIL rstmid_data_after: got %h want dead", last_acc); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int a0, f0;
        a0 = n_acc; f0 = n_ferr;
        ready = 1'b1;
        send_byte(8'h4f, 0, 1'b1);
        send_byte(8'h4f, 0, 1'b0);
        send_byte(8'h3e, 0, 1'b0);
        idle_bits(1);
        n_cmp++; if (n_ferr - f0 !== 1) begin n_fail++; $display("FAIL parity_pulses: got %0d want 1", n_ferr - f0); end
        n_cmp++; if (n_acc - a0 !== 1) begin n_fail++; $display("FAIL parity_words: got %0d want 1", n_acc - a0); end
        n_cmp++; if (last_acc !== 16'h4f3e) begin n_fail++; $display("FAIL parity_data: got %h want 4f3e", last_acc); end
    endtask
`endif

    initial begin
        rst     = 1'b1;
        uart_rx = 1'b1;
        ready   = 1'b0;
        test_reset;
        test_basic;
        test_overrun;
        test_frame_err;
        test_glitch;
        test_reset_mid;
`ifdef UART_RX_PARITY_EN
        test_parity;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
